// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: eight selectable ops on WIDTH-bit operands, SLICE bits per clock,
// with a START/BUSY/DONE handshake and ZERO/PARITY status flags.
module logic_unit_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             parity
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] full_res;
    logic             last_slice;
    logic             accept;

    always_comb begin
        accept     = start && (state != S_RUN);
        last_slice = (k == CW'(NSLICE - 1));
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_slice) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // busy/done are flops so they are glitch-free and mutually exclusive by construction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_RUN);
            done  <= (state_next == S_DONE);
        end
    end

    // The ops are purely bitwise, so the full-width result is sliced rather than computed per slice
    always_comb begin
        full_res = '0;
        case (op_q)
            3'b000:  full_res = a_q & b_q;
            3'b001:  full_res = a_q | b_q;
            3'b010:  full_res = ~(a_q | b_q);
            3'b011:  full_res = a_q ^ b_q;
            3'b100:  full_res = ~(a_q & b_q);
            3'b101:  full_res = ~(a_q ^ b_q);
            3'b110:  full_res = ~a_q;
            default: full_res = b_q;
        endcase
    end

    always_comb begin
        acc_next = acc;
        for (int s = 0; s < NSLICE; s++) begin
            if (k == CW'(s)) begin
                acc_next[s*SLICE +: SLICE] = full_res[s*SLICE +: SLICE];
            end
        end
    end

    // Published outputs only move on the final slice, so partial results never escape
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            k      <= '0;
            acc    <= '0;
            out    <= '0;
            zero   <= 1'b0;
            parity <= 1'b0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            k    <= '0;
            acc  <= '0;
        end else if (state == S_RUN) begin
            acc <= acc_next;
            if (last_slice) begin
                out    <= acc_next;
                zero   <= (acc_next == '0);
                parity <= ^acc_next;
            end else begin
                k <= k + CW'(1);
            end
        end
    end

endmodule
